std_spi_slave_tx_rx: RTL and testbench

SPI slave (responder) controller, MSB first, 8-bit transactions, fed by a standard transmit FIFO and draining into a standard receive FIFO. It samples the external master's SS/SCK/MOSI through synchronizers into the single `spi_clk` domain and drives MISO. It is the peer of our SPI master controller and is used on the peripheral side of the APB SPI subsystem, or in loopback benches against the master. Full-duplex, RX-only and TX-only operation are selected at run time.

---
 rtl/std_spi_slave_tx_rx_if.sv | 38 +++
 rtl/std_spi_slave_tx_rx.sv | 169 ++++++++++++++++
 tb/tb_std_spi_slave_tx_rx.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/std_spi_slave_tx_rx_if.sv
`default_nettype none
// ============================================================================
// std_spi_slave_tx_rx_if : FIFO, control and SPI pin bundle for the SPI slave.
// Revision: 1.0
// ============================================================================
interface std_spi_slave_tx_rx_if;
    logic [1:0] rx_tx_dire;
    logic       tx_fifo_ren;
    logic       tx_fifo_empty;
    logic [7:0] tx_fifo_dout;
    logic       rx_fifo_wen;
    logic       rx_fifo_full;
    logic [7:0] rx_fifo_din;
    logic       rx_tx_start;
    logic       rx_tx_done;
    logic       rx_err;
    logic       tx_underrun;
    logic       spi_ss;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;

    modport slave (
        input  rx_tx_dire, tx_fifo_empty, tx_fifo_dout, rx_fifo_full,
               spi_ss, spi_sck, spi_mosi,
        output tx_fifo_ren, rx_fifo_wen, rx_fifo_din, rx_tx_start, rx_tx_done,
               rx_err, tx_underrun, spi_miso, spi_miso_oe
    );

    modport master (
        output rx_tx_dire, tx_fifo_empty, tx_fifo_dout, rx_fifo_full,
               spi_ss, spi_sck, spi_mosi,
        input  tx_fifo_ren, rx_fifo_wen, rx_fifo_din, rx_tx_start, rx_tx_done,
               rx_err, tx_underrun, spi_miso, spi_miso_oe
    );
endinterface
`default_nettype wire

// File: rtl/std_spi_slave_tx_rx.sv
`default_nettype none
// ============================================================================
// std_spi_slave_tx_rx : MSB-first 8-bit SPI slave between a TX and an RX FIFO.
// Optional SPI_SLAVE_MISO_TRISTATE_EN releases MISO to 'z' while deselected.
// Revision: 1.0
// ============================================================================
module std_spi_slave_tx_rx #(
    parameter logic       SPI_CPOL   = 1'b0,
    parameter logic       SPI_CPHA   = 1'b0,
    parameter logic [7:0] DUMMY_BYTE = 8'hff
) (
    input  wire logic              spi_clk,
    input  wire logic              spi_resetn,
    std_spi_slave_tx_rx_if.slave   bus
);
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ss_q, sck_q;
    logic [1:0] mosi_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_din_q, rx_din_d;
    logic       load_pend_q, load_pend_d;
    logic       from_fifo_q, from_fifo_d;
    logic       byte_pend_q, byte_pend_d;
    logic       start_q, start_d;
    logic       done_q, done_d;
    logic       wen_q, wen_d;
    logic       err_q, err_d;
    logic       under_q, under_d;
    logic       oe_q, oe_d;
    logic       miso_q, miso_d;

    logic w_ss_fall, w_ss_rise, w_lead, w_trail, w_sample, w_shift;
    logic w_tx_en, w_rx_en, w_active, w_load_req, w_ren;

    // Index 1 is the synchronized level, index 2 its one-cycle history.
    assign w_ss_fall = ss_q[2] & ~ss_q[1];
    assign w_ss_rise = ~ss_q[2] & ss_q[1];
    assign w_lead    = (sck_q[1] != SPI_CPOL) && (sck_q[2] == SPI_CPOL);
    assign w_trail   = (sck_q[1] == SPI_CPOL) && (sck_q[2] != SPI_CPOL);
    assign w_sample  = SPI_CPHA ? w_trail : w_lead;
    assign w_shift   = SPI_CPHA ? w_lead  : w_trail;

    // Reserved direction 2'b00 behaves as TX only.
    assign w_tx_en   = bus.rx_tx_dire[0] | ~bus.rx_tx_dire[1];
    assign w_rx_en   = bus.rx_tx_dire[1];
    assign w_active  = (state_q == ST_ACTIVE) && !w_ss_rise;
    assign w_load_req = ((state_q == ST_IDLE) && w_ss_fall && !SPI_CPHA) ||
                        (w_active && w_shift && (bit_cnt_q == 3'd0));
    assign w_ren     = w_load_req & w_tx_en & ~bus.tx_fifo_empty;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_din_d    = rx_din_q;
        load_pend_d = w_load_req;
        from_fifo_d = w_ren;
        byte_pend_d = 1'b0;
        start_d     = 1'b0;
        done_d      = byte_pend_q;
        wen_d       = byte_pend_q & w_rx_en;
        err_d       = wen_q & bus.rx_fifo_full;
        under_d     = w_load_req & w_tx_en & bus.tx_fifo_empty;
        if (byte_pend_q && w_rx_en) begin
            rx_din_d = rx_shift_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_ss_fall) begin
                    state_d   = ST_ACTIVE;
                    start_d   = 1'b1;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_ACTIVE: begin
                // A deselect on the same cycle as a sample edge drops the sample.
                if (w_ss_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                end else begin
                    if (w_sample) begin
                        rx_shift_d  = {rx_shift_q[6:0], mosi_q[1]};
                        bit_cnt_d   = bit_cnt_q + 3'd1;
                        byte_pend_d = (bit_cnt_q == 3'd7);
                    end
                    if (w_shift && !w_load_req) begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // FIFO data arrives the cycle after the read strobe.
        if (load_pend_q) begin
            tx_shift_d = from_fifo_q ? bus.tx_fifo_dout : DUMMY_BYTE;
        end
        oe_d   = (state_d == ST_ACTIVE);
        miso_d = tx_shift_q[7];
    end

    always_ff @(posedge spi_clk or negedge spi_resetn) begin
        if (!spi_resetn) begin
            state_q     <= ST_IDLE;
            ss_q        <= 3'b111;
            sck_q       <= {3{SPI_CPOL}};
            mosi_q      <= 2'b00;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'h00;
            tx_shift_q  <= 8'hff;
            rx_din_q    <= 8'h00;
            load_pend_q <= 1'b0;
            from_fifo_q <= 1'b0;
            byte_pend_q <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            wen_q       <= 1'b0;
            err_q       <= 1'b0;
            under_q     <= 1'b0;
            oe_q        <= 1'b0;
            miso_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            ss_q        <= {ss_q[1:0], bus.spi_ss};
            sck_q       <= {sck_q[1:0], bus.spi_sck};
            mosi_q      <= {mosi_q[0], bus.spi_mosi};
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_din_q    <= rx_din_d;
            load_pend_q <= load_pend_d;
            from_fifo_q <= from_fifo_d;
            byte_pend_q <= byte_pend_d;
            start_q     <= start_d;
            done_q      <= done_d;
            wen_q       <= wen_d;
            err_q       <= err_d;
            under_q     <= under_d;
            oe_q        <= oe_d;
            miso_q      <= miso_d;
        end
    end

    assign bus.tx_fifo_ren = w_ren;
    assign bus.rx_fifo_wen = wen_q;
    assign bus.rx_fifo_din = rx_din_q;
    assign bus.rx_tx_start = start_q;
    assign bus.rx_tx_done  = done_q;
    assign bus.rx_err      = err_q;
    assign bus.tx_underrun = under_q;
    assign bus.spi_miso_oe = oe_q;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign bus.spi_miso = oe_q ? miso_q : 1'bz;
`else
    assign bus.spi_miso = miso_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_std_spi_slave_tx_rx.sv
`default_nettype none
// ============================================================================
// tb_std_spi_slave_tx_rx : runs all four SPI modes side by side against a
// FIFO/master model and checks bytes, strobes and counts per transaction.
// Revision: 1.0
// ============================================================================
module tb_std_spi_slave_tx_rx;
    localparam int N = 4;
    localparam int H = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] dire = 2'b11;
    logic       rx_full = 1'b0;
    logic       ss = 1'b1;
    logic       sck [N];
    logic       mosi [N];
    logic       tx_empty [N];
    logic [7:0] tx_dout [N] = '{default: 8'h00};
    logic       ren [N], wen [N], start [N], done [N], err [N], und [N], miso [N], oe [N];
    logic [7:0] din [N];

    logic [7:0] txmem [N][64];
    int         wr  [N];
    int         mrd [N];
    int         rd  [N] = '{default: 0};
    int         ren_cnt [N] = '{default: 0};
    int         wen_cnt [N] = '{default: 0};
    int         start_cnt [N] = '{default: 0};
    int         done_cnt [N] = '{default: 0};
    int         err_cnt [N] = '{default: 0};
    int         err_bad [N] = '{default: 0};
    int         und_cnt [N] = '{default: 0};
    logic       wen_prev [N] = '{default: 1'b0};
    logic [7:0] rxmem [N][64];
    logic [7:0] mo_bytes [8];
    logic [7:0] mi_bytes [N][8];
    int         checks = 0;
    int         failures = 0;

    for (genvar m = 0; m < N; m++) begin : g_dut
        std_spi_slave_tx_rx_if bus ();
        assign bus.rx_tx_dire    = dire;
        assign bus.tx_fifo_empty = tx_empty[m];
        assign bus.tx_fifo_dout  = tx_dout[m];
        assign bus.rx_fifo_full  = rx_full;
        assign bus.spi_ss        = ss;
        assign bus.spi_sck       = sck[m];
        assign bus.spi_mosi      = mosi[m];
        assign tx_empty[m]       = (rd[m] >= wr[m]);
        assign ren[m]   = bus.tx_fifo_ren;
        assign wen[m]   = bus.rx_fifo_wen;
        assign din[m]   = bus.rx_fifo_din;
        assign start[m] = bus.rx_tx_start;
        assign done[m]  = bus.rx_tx_done;
        assign err[m]   = bus.rx_err;
        assign und[m]   = bus.tx_underrun;
        assign miso[m]  = bus.spi_miso;
        assign oe[m]    = bus.spi_miso_oe;

        std_spi_slave_tx_rx #(
            .SPI_CPOL   (m >= 2),
            .SPI_CPHA   (m % 2 == 1),
            .DUMMY_BYTE (8'hff)
        ) u_dut (
            .spi_clk    (clk),
            .spi_resetn (rst_n),
            .bus        (bus)
        );
    end

    // Registered-read TX FIFO: data follows the read strobe by one cycle.
    always @(posedge clk) begin
        for (int m = 0; m < N; m++) begin
            if (ren[m]) begin
                tx_dout[m] <= txmem[m][rd[m] % 64];
                rd[m]      <= rd[m] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int m = 0; m < N; m++) begin
            if (ren[m])   ren_cnt[m]   <= ren_cnt[m] + 1;
            if (start[m]) start_cnt[m] <= start_cnt[m] + 1;
            if (done[m])  done_cnt[m]  <= done_cnt[m] + 1;
            if (und[m])   und_cnt[m]   <= und_cnt[m] + 1;
            if (wen[m]) begin
                rxmem[m][wen_cnt[m] % 64] <= din[m];
                wen_cnt[m] <= wen_cnt[m] + 1;
            end
            if (err[m]) begin
                err_cnt[m] <= err_cnt[m] + 1;
                if (!wen_prev[m]) err_bad[m] <= err_bad[m] + 1;
            end
            wen_prev[m] <= wen[m];
        end
    end

    task automatic push_all(input logic [7:0] b);
        for (int m = 0; m < N; m++) begin
            txmem[m][wr[m] % 64] = b;
            wr[m] = wr[m] + 1;
        end
    endtask

    // SPI master for all four modes at once; MISO is taken at each mode's sample edge.
    task automatic spi_xfer(input int nbits, input bit raise_ss);
        @(negedge clk);
        ss = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            int b;
            int k;
            b = i / 8;
            k = 7 - (i % 8);
            for (int m = 0; m < N; m++) if (m % 2 == 0) mosi[m] = mo_bytes[b][k];
            for (int m = 0; m < N; m++) begin
                sck[m] = (m < 2);
                if (m % 2 == 0) mi_bytes[m][b][k] = miso[m];
                else            mosi[m] = mo_bytes[b][k];
            end
            repeat (H) @(negedge clk);
            for (int m = 0; m < N; m++) begin
                sck[m] = (m >= 2);
                if (m % 2 == 1) mi_bytes[m][b][k] = miso[m];
            end
            repeat (H) @(negedge clk);
        end
        if (raise_ss) begin
            ss = 1'b1;
            repeat (2 * H) @(negedge clk);
        end
    endtask

    task automatic run_check(input string name, input int nbytes, input logic [1:0] d);
        int s_ren [N];
        int s_wen [N];
        int s_start [N];
        int s_done [N];
        int s_err [N];
        int s_und [N];
        dire = d;
        for (int m = 0; m < N; m++) begin
            s_ren[m] = ren_cnt[m];   s_wen[m] = wen_cnt[m];   s_start[m] = start_cnt[m];
            s_done[m] = done_cnt[m]; s_err[m] = err_cnt[m];   s_und[m] = und_cnt[m];
        end
        spi_xfer(nbytes * 8, 1'b1);
        for (int m = 0; m < N; m++) begin
            logic       tx_en;
            int         loads;
            int         e_ren;
            int         e_und;
            int         e_wen;
            logic [7:0] bt;
            tx_en = d[0] | ~d[1];
            loads = nbytes + ((m % 2 == 0) ? 1 : 0);
            e_ren = 0;
            e_und = 0;
            e_wen = d[1] ? nbytes : 0;
            for (int j = 0; j < loads; j++) begin
                bt = 8'hff;
                if (tx_en && mrd[m] < wr[m]) begin
                    bt = txmem[m][mrd[m] % 64];
                    mrd[m] = mrd[m] + 1;
                    e_ren++;
                end else if (tx_en) begin
                    e_und++;
                end
                if (j < nbytes) begin
                    checks++;
                    if (mi_bytes[m][j] !== bt) begin
                        failures++;
                        $display("FAIL %s mode%0d miso_byte%0d: got %h expected %h", name, m, j, mi_bytes[m][j], bt);
                    end
                    if (d[1]) begin
                        checks++;
                        if (rxmem[m][(s_wen[m] + j) % 64] !== mo_bytes[j]) begin
                            failures++;
                            $display("FAIL %s mode%0d rx_byte%0d: got %h expected %h", name, m, j, rxmem[m][(s_wen[m] + j) % 64], mo_bytes[j]);
                        end
                    end
                end
            end
            checks++;
            if (ren_cnt[m] - s_ren[m] !== e_ren) begin
                failures++;
                $display("FAIL %s mode%0d ren_count: got %0d expected %0d", name, m, ren_cnt[m] - s_ren[m], e_ren);
            end
            checks++;
            if (und_cnt[m] - s_und[m] !== e_und) begin
                failures++;
                $display("FAIL %s mode%0d underrun_count: got %0d expected %0d", name, m, und_cnt[m] - s_und[m], e_und);
            end
            checks++;
            if (wen_cnt[m] - s_wen[m] !== e_wen) begin
                failures++;
                $display("FAIL %s mode%0d wen_count: got %0d expected %0d", name, m, wen_cnt[m] - s_wen[m], e_wen);
            end
            checks++;
            if (done_cnt[m] - s_done[m] !== nbytes) begin
                failures++;
                $display("FAIL %s mode%0d done_count: got %0d expected %0d", name, m, done_cnt[m] - s_done[m], nbytes);
            end
            checks++;
            if (start_cnt[m] - s_start[m] !== 1) begin
                failures++;
                $display("FAIL %s mode%0d start_count: got %0d expected 1", name, m, start_cnt[m] - s_start[m]);
            end
            checks++;
            if (err_cnt[m] - s_err[m] !== (rx_full ? e_wen : 0) || err_bad[m] !== 0) begin
                failures++;
                $display("FAIL %s mode%0d rx_err: got %0d (misplaced %0d) expected %0d", name, m, err_cnt[m] - s_err[m], err_bad[m], rx_full ? e_wen : 0);
            end
            checks++;
            if (rd[m] !== mrd[m]) begin
                failures++;
                $display("FAIL %s mode%0d fifo_reads_total: got %0d expected %0d", name, m, rd[m], mrd[m]);
            end
        end
    endtask

    task automatic check_reset_values(input string name);
        for (int m = 0; m < N; m++) begin
            checks++;
            if ({ren[m], wen[m], start[m], done[m], err[m], und[m], oe[m]} !== 7'b0) begin
                failures++;
                $display("FAIL %s mode%0d strobes: got %b expected 0000000", name, m, {ren[m], wen[m], start[m], done[m], err[m], und[m], oe[m]});
            end
            checks++;
            if (miso[m] !== 1'b1) begin
                failures++;
                $display("FAIL %s mode%0d miso: got %b expected 1", name, m, miso[m]);
            end
            checks++;
            if (din[m] !== 8'h00) begin
                failures++;
                $display("FAIL %s mode%0d rx_fifo_din: got %h expected 00", name, m, din[m]);
            end
        end
    endtask

    task automatic test_reset;
        repeat (4) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_full_duplex;
        push_all(8'hA5);
        mo_bytes[0] = 8'h3C;
        run_check("full_duplex", 1, 2'b11);
    endtask

    task automatic test_burst;
        push_all(8'h01); push_all(8'h80); push_all(8'hFF);
        mo_bytes[0] = 8'hC3; mo_bytes[1] = 8'h5A; mo_bytes[2] = 8'h00;
        run_check("burst", 3, 2'b11);
    endtask

    task automatic test_tx_empty;
        mo_bytes[0] = 8'($urandom);
        run_check("tx_empty", 1, 2'b11);
    endtask

    task automatic test_rx_only;
        push_all(8'h5A);
        mo_bytes[0] = 8'($urandom);
        run_check("rx_only", 1, 2'b10);
    endtask

    task automatic test_overflow;
        rx_full = 1'b1;
        mo_bytes[0] = 8'($urandom);
        run_check("overflow", 1, 2'b11);
        rx_full = 1'b0;
    endtask

    task automatic test_abort;
        int s_wen [N];
        int s_done [N];
        dire = 2'b11;
        push_all(8'($urandom));
        for (int m = 0; m < N; m++) begin
            s_wen[m] = wen_cnt[m];
            s_done[m] = done_cnt[m];
        end
        mo_bytes[0] = 8'($urandom);
        spi_xfer(5, 1'b1);
        for (int m = 0; m < N; m++) begin
            if (mrd[m] < wr[m]) mrd[m] = mrd[m] + 1;
            checks++;
            if (wen_cnt[m] !== s_wen[m] || done_cnt[m] !== s_done[m]) begin
                failures++;
                $display("FAIL abort mode%0d partial_byte: got wen %0d done %0d expected 0 0", m, wen_cnt[m] - s_wen[m], done_cnt[m] - s_done[m]);
            end
        end
        mo_bytes[0] = 8'h96;
        run_check("after_abort", 1, 2'b11);
    endtask

    task automatic test_random;
        for (int it = 0; it < 6; it++) begin
            int nb;
            int np;
            nb = int'($urandom_range(1, 4));
            np = int'($urandom_range(0, nb + 1));
            for (int j = 0; j < nb; j++) mo_bytes[j] = 8'($urandom);
            for (int j = 0; j < np; j++) push_all(8'($urandom));
            run_check("random", nb, 2'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_midbyte;
        mo_bytes[0] = 8'($urandom);
        dire = 2'b10;
        spi_xfer(3, 1'b0);
        for (int m = 0; m < N; m++) begin
            checks++;
            if (oe[m] !== 1'b1) begin
                failures++;
                $display("FAIL midbyte mode%0d miso_oe: got %b expected 1", m, oe[m]);
            end
        end
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_midbyte");
        ss = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        for (int m = 0; m < N; m++) begin
            sck[m]  = (m >= 2);
            mosi[m] = 1'b0;
            wr[m]   = 0;
            mrd[m]  = 0;
        end
        test_reset();
        test_full_duplex();
        test_burst();
        test_tx_empty();
        test_rx_only();
        test_overflow();
        test_abort();
        test_random();
        test_reset_midbyte();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
